// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : stopwatch_ctrl                                                |
// | Brief    : button debounce, IDLE/RUN/PAUSE control and BCD 00-99 count   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module stopwatch_ctrl #(
  parameter int TICK_WAIT = 27_000_000,
  parameter int TICK_BITS = 25,
  parameter int DEB_WAIT  = 270_000,
  parameter int DEB_BITS  = 19
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn_ss,
  input  logic       i_btn_clr,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones,
  output logic       o_running,
  output logic       o_tick,
  output logic       o_wrap
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_PAUSE = 2'd2;

  localparam logic [DEB_BITS-1:0]  c_DEB_LAST  = DEB_BITS'(DEB_WAIT - 1);
  localparam logic [DEB_BITS-1:0]  c_DEB_ONE   = DEB_BITS'(1);
  localparam logic [TICK_BITS-1:0] c_TICK_LAST = TICK_BITS'(TICK_WAIT - 1);
  localparam logic [TICK_BITS-1:0] c_TICK_ONE  = TICK_BITS'(1);
  localparam logic [3:0]           c_NINE      = 4'd9;
  localparam logic [3:0]           c_DIG_ONE   = 4'd1;

  logic [1:0] w_btn_raw;
  logic [1:0] w_press;

  assign w_btn_raw = {i_btn_clr, i_btn_ss};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic                r_meta;
      logic                r_sync;
      logic                r_deb;
      logic [DEB_BITS-1:0] r_cnt;
      logic                w_settled;

      assign w_settled = (r_sync != r_deb) && (r_cnt == c_DEB_LAST);

      always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
          r_meta <= 1'b1;
          r_sync <= 1'b1;
          r_deb  <= 1'b1;
          r_cnt  <= '0;
        end else begin
          r_meta <= w_btn_raw[gi];
          r_sync <= r_meta;
          if ((r_sync == r_deb) || w_settled)
            r_cnt <= '0;
          else
            r_cnt <= r_cnt + c_DEB_ONE;
          if (w_settled)
            r_deb <= r_sync;
        end
      end

      // Event fires in the cycle the accepted level is about to fall.
      assign w_press[gi] = w_settled && r_deb;
    end
  endgenerate

  logic                 w_ss_evt;
  logic                 w_clr_evt;
  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [TICK_BITS-1:0] r_pre;
  logic [3:0]           r_tens;
  logic [3:0]           r_ones;
  logic                 r_running;
  logic                 r_tick;
  logic                 r_wrap;
  logic                 w_terminal;
  logic                 w_tick;
  logic                 w_wrap;

  assign w_ss_evt  = w_press[0];
  assign w_clr_evt = w_press[1];

  always_comb begin
    w_state_nxt = r_state;
    if (w_clr_evt) begin
      w_state_nxt = c_IDLE;
    end else if (w_ss_evt) begin
      case (r_state)
        c_IDLE:  w_state_nxt = c_RUN;
        c_RUN:   w_state_nxt = c_PAUSE;
        c_PAUSE: w_state_nxt = c_RUN;
        default: w_state_nxt = c_IDLE;
      endcase
    end
  end

  // A clear in the terminal cycle suppresses the tick entirely.
  assign w_terminal = (r_state == c_RUN) && (r_pre == c_TICK_LAST);
  assign w_tick     = w_terminal && !w_clr_evt;
  assign w_wrap     = w_tick && (r_tens == c_NINE) && (r_ones == c_NINE);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= c_IDLE;
      r_pre     <= '0;
      r_tens    <= '0;
      r_ones    <= '0;
      r_running <= 1'b0;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == c_RUN);
      r_tick    <= w_tick;
      r_wrap    <= w_wrap;
      if (w_clr_evt) begin
        r_pre  <= '0;
        r_tens <= '0;
        r_ones <= '0;
      end else if (r_state == c_RUN) begin
        if (w_terminal) begin
          r_pre <= '0;
          if (r_ones == c_NINE) begin
            r_ones <= '0;
            r_tens <= (r_tens == c_NINE) ? 4'd0 : r_tens + c_DIG_ONE;
          end else begin
            r_ones <= r_ones + c_DIG_ONE;
          end
        end else begin
          r_pre <= r_pre + c_TICK_ONE;
        end
      end else if (r_state == c_IDLE) begin
        r_pre <= '0;
      end
    end
  end

  assign o_tens    = r_tens;
  assign o_ones    = r_ones;
  assign o_running = r_running;
  assign o_tick    = r_tick;
  assign o_wrap    = r_wrap;

endmodule
`default_nettype wire

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control front end for the two-digit 7-segment stopwatch. It debounces the two active-low board push-buttons (start/stop and clear) and runs an IDLE/RUN/PAUSE state machine. It generates the counting tick from the 27 MHz clock and maintains a BCD 00–99 count. The outputs `o_tens`/`o_ones` feed the downstream segment-scan/decoder stage directly.

## Interface
- `TICK_WAIT`, 27_000_000, clock cycles per count increment (1 s at 27 MHz); minimum 2.
- `TICK_BITS`, 25, prescaler width; must satisfy 2^TICK_BITS ≥ TICK_WAIT.
- `DEB_WAIT`, 270_000, consecutive stable cycles required to accept a button level (10 ms); minimum 2.
- `DEB_BITS`, 19, debounce counter width; must satisfy 2^DEB_BITS ≥ DEB_WAIT.

Ports:
- `i_clk` input 1: system clock, all logic on rising edge.
- `i_rst` input 1: asynchronous, active-low reset.
- `i_btn_ss` input 1: start/stop button, raw, asynchronous, active-low (0 = pressed).
- `i_btn_clr` input 1: clear button, raw, asynchronous, active-low.
- `o_tens` output 4: BCD tens digit, 0–9.
- `o_ones` output 4: BCD ones digit, 0–9.
- `o_running` output 1: 1 while in RUN.
- `o_tick` output 1: one-cycle pulse in the cycle the count register updates.
- `o_wrap` output 1: one-cycle pulse coincident with `o_tick` when the count goes 99→00.

## Operation
- **Synchronizer.** Each button passes through a 2-FF synchronizer. Reset value is 1 (released).
- **Debouncer (per button).**
  - Holds the accepted level `deb`, reset value 1.
  - The counter increments while the synchronized level ≠ `deb`.
  - The counter clears to 0 whenever the synchronized level = `deb`.
  - When the counter reaches `DEB_WAIT-1`, `deb` takes the synchronized level and the counter clears.
  - Glitches shorter than `DEB_WAIT` cycles never change `deb`.
- **Press event.** A one-cycle internal pulse generated on the `deb` 1→0 transition only. Release produces no event. Holding a button produces exactly one event.
- **FSM states:** IDLE, RUN, PAUSE. Reset state is IDLE.
  - IDLE: start/stop event → RUN.
  - RUN: start/stop event → PAUSE.
  - PAUSE: start/stop event → RUN.
  - Clear event in any state → IDLE. Count forced to 00 and prescaler forced to 0.
  - Start/stop and clear events in the same cycle: clear wins, next state IDLE.
- **Prescaler.**
  - Increments only in cycles where state = RUN.
  - Holds its value in PAUSE, so a resumed run completes the partial second.
  - Zero in IDLE.
  - At `TICK_WAIT-1` while in RUN it returns to 0 and the count increments.
- **BCD count.**
  - Ones 0–8 → ones+1.
  - Ones 9 → ones 0 with tens+1.
  - 99 → 00 and `o_wrap` pulses.
  - Digits never leave 0–9.
- **Tick versus clear.** A tick and a clear event in the same cycle resolve as clear: count 00, no `o_tick`, no `o_wrap`.
- **Registered outputs.** All outputs are registered; none is combinational from inputs.

## Timing
- **Reset values.** While `i_rst`=0: `o_tens`=0, `o_ones`=0, `o_running`=0, `o_tick`=0, `o_wrap`=0, state IDLE, both prescaler and debounce counters 0.
  - Reset deassertion with a button already held produces a press event after the debounce time. This is intended.
- **Button latency.** From a clean raw press edge to the internal event: 2 synchronizer cycles + `DEB_WAIT` cycles, ±1.
  - `o_running` changes 1 cycle after the event.
  - The bench accepts `DEB_WAIT`+2 to `DEB_WAIT`+4 cycles from raw edge to `o_running` change.
- **First increment.** Occurs on the `TICK_WAIT`-th rising edge counted from the first cycle with `o_running`=1.
  - That is, `o_tick`=1 and the new digits are visible in the same cycle, exactly `TICK_WAIT` cycles after `o_running` rises.
  - Subsequent ticks follow every `TICK_WAIT` cycles while in RUN.
- **Pause and resume.** Cycles spent in PAUSE do not count. The total RUN cycles between consecutive ticks is always `TICK_WAIT`.
- **Clear latency.** Digits read 00 and `o_running`=0 one cycle after the clear event.
- **Reset mid-operation.** Asynchronous reset takes effect immediately, independent of `i_clk`.

## Test plan
Bench parameters: `TICK_WAIT`=10, `DEB_WAIT`=4.

1. **Reset.** Assert `i_rst`=0 mid-RUN with count 37 → all outputs 0 immediately, with no clock edge required. After release, with buttons at 1, outputs stay 0 for 100 cycles.
2. **Debounce.** On `i_btn_ss`, apply 3-cycle low pulses repeated 5 times with 1-cycle high gaps → `o_running` stays 0. Then hold low for 8 cycles → `o_running`=1 within 6–8 cycles of the edge, and only one transition.
3. **Counting and wrap.** Start, then run 1000 cycles → `o_tick` pulses every 10 cycles. Digits go 00→01…→09→10 (`o_tens`=1, `o_ones`=0). After the 100th tick the digits read 00, `o_wrap`=1 for exactly that cycle, and `o_tick`=1.
4. **Pause and resume.** Start, pause 6 RUN-cycles after entry, stay in PAUSE 50 cycles, then resume → first tick exactly 4 RUN-cycles after `o_running` re-rises, and count 01.
5. **Clear priority.** Press start/stop and clear simultaneously from RUN at count 25 → state IDLE, digits 00, `o_running`=0. Force the clear event coincident with a prescaler terminal count → no `o_tick` or `o_wrap`, digits 00.
6. **Held button.** Hold `i_btn_ss` low for 200 cycles from IDLE → exactly one IDLE→RUN transition. Release, then press again → PAUSE, with digits frozen at their current value.
